uart_tx_arbiter: RTL and testbench

//  Shares the single Uart8 transmitter between N_REQ byte producers. Round-robin

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the Uart8 transmit-side arbiter: controller state
// encoding (reused by future rx-side controllers) and the latched-transfer record.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } xfer_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching from ptr+1
// upward with wrap-around; ptr itself is checked last.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        pick[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one Uart8 transmitter between N_REQ byte producers: round-robin grant,
// packets locked to one owner until its last byte, watchdog on unacknowledged starts.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [N_REQ-1:0]   reqValid,
  input  logic [N_REQ-1:0]   reqLast,
  input  logic [8*N_REQ-1:0] reqData,
  output logic [N_REQ-1:0]   reqReady,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   doneP,
  output logic [N_REQ-1:0]   errP,
  output logic               txEn,
  output logic               txStart,
  output logic [7:0]         txData,
  input  logic               txBusy,
  input  logic               txDone
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  xfer_t            xfer_q, xfer_d;
  logic             lock_q, lock_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic             start_q, start_d;
  logic             en_q, en_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             complete;

  // While locked grant_q still holds the owner's one-hot, so it doubles as the eligibility mask.
  assign elig = lock_q ? (reqValid & grant_q) : reqValid;

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req  (elig),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    xfer_d   = xfer_q;
    lock_d   = lock_q;
    timer_d  = timer_q;
    grant_d  = grant_q;
    ready_d  = '0;
    done_d   = '0;
    err_d    = '0;
    start_d  = 1'b0;
    en_d     = 1'b1;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A UART still busy (e.g. reset released mid-frame) must finish before any new start.
        if (!txBusy && pick_any) begin
          owner_d     = pick_idx;
          xfer_d.data = reqData[{pick_idx, 3'b000} +: 8];
          xfer_d.last = reqLast[pick_idx];
          grant_d     = pick;
          ready_d     = pick;
          start_d     = 1'b1;
          timer_d     = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        timer_d = timer_q + TW'(1);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        timer_d = timer_q + TW'(1);
        if (txDone) begin
          complete = 1'b1;
        end else if (txBusy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q >= TW'(START_TIMEOUT - 1)) begin
          err_d    = grant_q;
          lock_d   = 1'b0;
          rr_ptr_d = owner_q;
          grant_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: complete = txDone;
      default:      state_d  = ST_IDLE;
    endcase

    if (complete) begin
      done_d  = grant_q;
      state_d = ST_IDLE;
      if (xfer_q.last) begin
        lock_d   = 1'b0;
        rr_ptr_d = owner_q;
        grant_d  = '0;
      end else begin
        lock_d = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(N_REQ - 1);
      xfer_q   <= '0;
      lock_q   <= 1'b0;
      timer_q  <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      xfer_q   <= xfer_d;
      lock_q   <= lock_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      en_q     <= en_d;
    end
  end

  assign reqReady = ready_q;
  assign grant    = grant_q;
  assign doneP    = done_q;
  assign errP     = err_q;
  assign txEn     = en_q;
  assign txStart  = start_q;
  assign txData   = xfer_q.data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: random packet producers and a stub UART,
// scored against a transaction-level round-robin/lock model, plus a directed reset case.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int BYTES    = 10;
  localparam int MAX_CYC  = 20000;
  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_EARLY  = 2;
  localparam int M_LIMIT  = 3;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   req_valid, req_last, req_ready, grant, done_p, err_p;
  logic [8*N-1:0] req_data;
  logic           tx_en, tx_start, tx_busy, tx_done;
  logic [7:0]     tx_data;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .reqValid (req_valid),
    .reqLast  (req_last),
    .reqData  (req_data),
    .reqReady (req_ready),
    .grant    (grant),
    .doneP    (done_p),
    .errP     (err_p),
    .txEn     (tx_en),
    .txStart  (tx_start),
    .txData   (tx_data),
    .txBusy   (tx_busy),
    .txDone   (tx_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state: packet lock, round-robin pointer, transfer in flight.
  bit         lock = 1'b0;
  int         lock_owner = 0;
  int         rr_ptr = N - 1;
  bit         inflight = 1'b0;
  int         owner = 0;
  bit         own_last = 1'b0;
  logic [7:0] own_byte = '0;

  // Stub UART and producer state.
  bit stub_on = 1'b0;
  bit done_driven = 1'b0;
  int stub_mode = 0, stub_j = 0, busy_at = 0, done_at = 0;
  int left[N], pkt_left[N], gap[N];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int predict(input logic [N-1:0] v);
    if (lock) return v[lock_owner] ? lock_owner : -1;
    for (int k = 1; k <= N; k++)
      if (v[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    return -1;
  endfunction

  initial begin : main
    logic [N-1:0] exp_ready, exp_done, exp_err, exp_grant;
    int exp_owner, sent, cycles, r;
    exp_ready = '0;
    exp_owner = -1;
    sent      = 0;
    cycles    = 0;

    rstN = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = BYTES; pkt_left[i] = 0; gap[i] = int'($urandom_range(3, 0));
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req_ready, grant, done_p, err_p, tx_en, tx_start, tx_data}), 32'd0);
    rstN = 1'b1;

    while (sent < N * BYTES && cycles < MAX_CYC) begin
      @(negedge clk);
      cycles++;
      if (stub_on) stub_j++;
      if (cycles == 1) check("tx_en_after_reset", 32'(tx_en), 32'd1);

      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("tx_start", 32'(tx_start), 32'(|exp_ready));

      exp_done = (inflight && done_driven) ? onehot(owner) : '0;
      exp_err  = (inflight && stub_on && stub_mode == M_NOACK && stub_j == TO) ? onehot(owner) : '0;
      done_driven = 1'b0;
      check("doneP", 32'(done_p), 32'(exp_done));
      check("errP", 32'(err_p), 32'(exp_err));

      if (exp_ready != '0) begin
        inflight = 1'b1;
        owner    = exp_owner;
        own_last = req_last[owner];
        own_byte = req_data[8*owner +: 8];
        check("tx_data_load", 32'(tx_data), 32'(own_byte));
        stub_on = 1'b1;
        stub_j  = 0;
        r = int'($urandom_range(9, 0));
        stub_mode = (r <= 5) ? M_NORMAL : (r == 6) ? M_NOACK : (r <= 8) ? M_EARLY : M_LIMIT;
        busy_at = int'($urandom_range(4, 1));
        done_at = (stub_mode == M_NORMAL) ? busy_at + int'($urandom_range(10, 3)) :
                  (stub_mode == M_EARLY)  ? int'($urandom_range(14, 1)) : TO - 1;
      end

      if (exp_done != '0) begin
        check("tx_data_hold", 32'(tx_data), 32'(own_byte));
        if (own_last) begin
          lock = 1'b0; rr_ptr = owner;
        end else begin
          lock = 1'b1; lock_owner = owner;
        end
        inflight = 1'b0; stub_on = 1'b0; sent++;
      end
      if (exp_err != '0) begin
        lock = 1'b0; rr_ptr = owner;
        inflight = 1'b0; stub_on = 1'b0; sent++;
      end

      exp_grant = inflight ? onehot(owner) : (lock ? onehot(lock_owner) : '0);
      check("grant", 32'(grant), 32'(exp_grant));

      tx_busy = 1'b0;
      tx_done = 1'b0;
      if (stub_on && stub_mode != M_NOACK) begin
        tx_busy = (stub_mode == M_NORMAL) && stub_j >= busy_at && stub_j < done_at;
        tx_done = (stub_j == done_at);
        if (tx_done) done_driven = 1'b1;
      end

      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          req_valid[i] = 1'b0;
          gap[i] = int'($urandom_range(3, 0));
        end else if (!req_valid[i] && left[i] > 0) begin
          if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            if (pkt_left[i] == 0) begin
              pkt_left[i] = int'($urandom_range(3, 1));
              if (pkt_left[i] > left[i]) pkt_left[i] = left[i];
            end
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i]  = (pkt_left[i] == 1);
            req_valid[i] = 1'b1;
            pkt_left[i]--;
            left[i]--;
          end
        end
      end

      exp_owner = inflight ? -1 : predict(req_valid);
      exp_ready = (exp_owner >= 0) ? onehot(exp_owner) : '0;
    end
    check("random_phase_complete", 32'(sent), 32'(N * BYTES));

    // Reset mid-frame, released while the UART is still busy.
    req_valid = 4'b0010; req_last = '1; req_data[15:8] = 8'hA5;
    for (int k = 0; k < 10 && !tx_start; k++) @(negedge clk);
    check("dir_start", 32'(tx_start), 32'd1);
    req_valid = '0;
    tx_busy   = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("dir_reset_outputs", 32'({req_ready, grant, done_p, err_p, tx_en, tx_start, tx_data}), 32'd0);
    req_valid = 4'b0101; req_data[7:0] = 8'h3C; req_data[23:16] = 8'hC3;
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("dir_busy_no_start", 32'(tx_start), 32'd0);
      check("dir_busy_no_grant", 32'(grant), 32'd0);
    end
    check("dir_tx_en", 32'(tx_en), 32'd1);
    tx_busy = 1'b0;
    @(negedge clk);
    check("dir_ready_req0", 32'(req_ready), 32'b0001);
    check("dir_start_req0", 32'(tx_start), 32'd1);
    check("dir_grant_req0", 32'(grant), 32'b0001);
    check("dir_data_req0", 32'(tx_data), 32'h3C);
    req_valid[0] = 1'b0;
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("dir_done_req0", 32'(done_p), 32'b0001);
    check("dir_grant_free", 32'(grant), 32'd0);
    @(negedge clk);
    check("dir_ready_req2", 32'(req_ready), 32'b0100);
    check("dir_data_req2", 32'(tx_data), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
